// File: rtl/quad_tach_gen.sv
// Quadrature tach generator: emits a programmed number of {B,A} quadrature steps at a
// programmed prescaled rate and direction, loaded byte-wise from a shared write bus.
module quad_tach_gen #(
  parameter logic [1:0] RESETPHASE = 2'b00,
  parameter bit         DIRINV     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wrtdata,
  input  logic       ldcntl,
  input  logic       ldcnth,
  input  logic       ldperiod,
  input  logic       dir,
  input  logic       start,
  input  logic       stop,
  input  logic       stepce,
  output logic [1:0] tach,
  output logic       busy,
  output logic       done,
  output logic [7:0] remainl,
  output logic [7:0] remainh
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  tach_q;
  logic [15:0] count;
  logic [7:0]  period;
  logic [7:0]  prescaler;
  logic        dirlat;
  logic        done_q;

  logic        launch;
  logic        step;
  logic        zero_done;
  logic        finish_done;

  // Gray-coded walk 00->01->11->10->00 forward; rev walks it backwards.
  function automatic logic [1:0] advance(input logic [1:0] cur, input logic rev);
    logic [1:0] nxt;
    case (cur)
      2'b00:   nxt = rev ? 2'b10 : 2'b01;
      2'b01:   nxt = rev ? 2'b00 : 2'b11;
      2'b11:   nxt = rev ? 2'b01 : 2'b10;
      default: nxt = rev ? 2'b11 : 2'b00;
    endcase
    return nxt;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    launch      = 1'b0;
    step        = 1'b0;
    zero_done   = 1'b0;
    finish_done = 1'b0;
    case (state_q)
      IDLE: begin
        // Start decision uses the count held before any same-cycle byte load.
        if (start && !stop) begin
          if (count != 16'd0) begin
            state_d = RUN;
            launch  = 1'b1;
          end else begin
            zero_done = 1'b1;
          end
        end
      end
      RUN: begin
        if (stepce && prescaler == 8'd0) begin
          step = 1'b1;
          if (count == 16'd1) begin
            state_d     = IDLE;
            finish_done = !stop;
          end
        end
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tach_q    <= RESETPHASE;
      count     <= 16'd0;
      period    <= 8'd0;
      prescaler <= 8'd0;
      dirlat    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= zero_done | finish_done;
      if (ldperiod) period <= wrtdata;
      if (state_q == IDLE) begin
        if (ldcntl) count[7:0]  <= wrtdata;
        if (ldcnth) count[15:8] <= wrtdata;
      end
      if (launch) begin
        prescaler <= period;
        dirlat    <= dir ^ DIRINV;
      end
      // A period write lands at the next reload because the reload reads the old register.
      if (step) begin
        tach_q    <= advance(tach_q, dirlat);
        count     <= count - 16'd1;
        prescaler <= period;
      end else if (state_q == RUN && stepce) begin
        prescaler <= prescaler - 8'd1;
      end
    end
  end

  assign tach    = tach_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign remainl = count[7:0];
  assign remainh = count[15:8];

endmodule

// File: tb/tb_quad_tach_gen.sv
// Randomized scoreboard bench for quad_tach_gen: two builds (DIRINV 0/1, different reset
// phases) share stimulus and are compared every cycle against an index-based step model.
module tb_quad_tach_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wrtdata;
  logic       ldcntl, ldcnth, ldperiod, dir, start, stop, stepce;

  logic [1:0] tach0, tach1;
  logic       busy0, busy1, done0, done1;
  logic [7:0] reml0, reml1, remh0, remh1;

  always #5 clk = ~clk;

  quad_tach_gen #(.RESETPHASE(2'b00), .DIRINV(1'b0)) dut0 (
    .clk(clk), .reset(reset), .wrtdata(wrtdata), .ldcntl(ldcntl), .ldcnth(ldcnth),
    .ldperiod(ldperiod), .dir(dir), .start(start), .stop(stop), .stepce(stepce),
    .tach(tach0), .busy(busy0), .done(done0), .remainl(reml0), .remainh(remh0));

  quad_tach_gen #(.RESETPHASE(2'b10), .DIRINV(1'b1)) dut1 (
    .clk(clk), .reset(reset), .wrtdata(wrtdata), .ldcntl(ldcntl), .ldcnth(ldcnth),
    .ldperiod(ldperiod), .dir(dir), .start(start), .stop(stop), .stepce(stepce),
    .tach(tach1), .busy(busy1), .done(done1), .remainl(reml1), .remainh(remh1));

  // Reference model: position on the quadrature circle as an index into the sequence.
  typedef struct {
    int phase;
    int count;
    int period;
    int presc;
    bit run;
    bit rev;
    bit done;
  } mdl_t;

  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         rst_idx [2] = '{0, 3};
  bit         inv [2] = '{1'b0, 1'b1};

  mdl_t        m [2];
  logic [19:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          pushes = 0;
  int          pops = 0;
  int          cyc_n = 0;

  function automatic mdl_t model_step(mdl_t s, int idx, bit r, int wd, bit ll, bit lh,
                                      bit lp, bit d, bit st, bit sp, bit ce);
    mdl_t n;
    n = s;
    n.done = 1'b0;
    if (r) begin
      n.phase = rst_idx[idx];
      n.count = 0;
      n.period = 0;
      n.presc = 0;
      n.run = 1'b0;
      n.rev = 1'b0;
      return n;
    end
    if (lp) n.period = wd;
    if (!s.run) begin
      if (ll) n.count = (n.count & 'hff00) | wd;
      if (lh) n.count = (n.count & 'h00ff) | (wd << 8);
      if (st && !sp) begin
        if (s.count != 0) begin
          n.run = 1'b1;
          n.presc = s.period;
          n.rev = d ^ inv[idx];
        end else begin
          n.done = 1'b1;
        end
      end
    end else begin
      if (ce) begin
        if (s.presc > 0) begin
          n.presc = s.presc - 1;
        end else begin
          n.phase = s.rev ? (s.phase + 3) % 4 : (s.phase + 1) % 4;
          n.count = (s.count - 1) & 'hffff;
          n.presc = s.period;
          if (s.count == 1) begin
            n.run = 1'b0;
            n.done = !sp;
          end
        end
      end
      if (sp) n.run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [19:0] model_out(mdl_t s);
    logic [15:0] c;
    c = 16'(s.count);
    return {seq[s.phase], s.run, s.done, c};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
    checks++;
    if (act !== req)
    begin
      errors++;
      $display("FAIL %s cycle %0d: got tach=%b busy=%b done=%b remain=%h, want tach=%b busy=%b done=%b remain=%h",
               name, cyc_n, act[19:18], act[17], act[16], act[15:0],
               req[19:18], req[17], req[16], req[15:0]);
    end
  endtask

  // One clock: present inputs, let the model take the same edge, queue its expectation.
  task automatic cyc(input bit r, input int wd, input bit ll, input bit lh, input bit lp,
                     input bit d, input bit st, input bit sp, input bit ce);
    reset = r; wrtdata = 8'(wd); ldcntl = ll; ldcnth = lh; ldperiod = lp;
    dir = d; start = st; stop = sp; stepce = ce;
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = model_step(m[i], i, r, wd, ll, lh, lp, d, st, sp, ce);
    exp_q.push_back(model_out(m[0]));
    exp_q.push_back(model_out(m[1]));
    pushes += 2;
    cyc_n++;
    #1;
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    logic [19:0] e0, e1;
    forever begin
      @(negedge clk);
      if (exp_q.size() >= 2) begin
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        pops += 2;
        check("dirinv0", {tach0, busy0, done0, remh0, reml0}, e0);
        check("dirinv1", {tach1, busy1, done1, remh1, reml1}, e1);
      end
    end
  end

  initial begin
    int wd;
    for (int i = 0; i < 2; i++) m[i] = '{0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    // Reset, then a count=4, period=0 forward run with stepce always high.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 1);
    cyc(0, 4, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Same with reverse direction.
    cyc(0, 4, 1, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // start with count=0, then start+stop together.
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 2, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // period=3, stepce every 2nd clock, count=2.
    cyc(0, 3, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, i % 2 == 1);
    // count=0x0100, stop after 5 steps, ldcnth while busy, then resume to completion.
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 9, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 256; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Reset in the middle of a run.
    cyc(0, 9, 1, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Randomized traffic with every strobe combination reachable.
    for (int i = 0; i < 6000; i++) begin
      wd = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom_range(0, 6));
      cyc($urandom_range(0, 999) < 2,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : wd,
          $urandom % 12 == 0,
          $urandom % 40 == 0,
          $urandom % 20 == 0,
          $urandom % 2 == 1,
          $urandom % 8 == 0,
          $urandom % 40 == 0,
          $urandom % 10 < 6);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pops != pushes) begin
      errors++;
      $display("FAIL drain: compared %0d, required %0d", pops, pushes);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
